// File: rtl/vram_arb_pkg.sv
// Shared encodings for the VRAM port arbiter: read-return tags and write-grant owner.
// No logic. Latency and backpressure are defined by the modules that import it.
package vram_arb_pkg;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_VID  = 2'd1,
        TAG_CPU  = 2'd2
    } rd_tag_e;

    typedef enum logic {
        GRANT_CPU = 1'b0,
        GRANT_DMA = 1'b1
    } wr_grant_e;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter (CPU/DMA). Grant is combinational, so there is no added latency.
// On a tie, the requester that was not granted last wins. The history register only moves on a grant.
module rr_arbiter_2
    import vram_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_cpu_i,
    input  logic req_dma_i,
    output logic gnt_cpu_o,
    output logic gnt_dma_o
);

    wr_grant_e last_q, last_d;

    always_comb begin
        gnt_cpu_o = 1'b0;
        gnt_dma_o = 1'b0;
        last_d    = last_q;
        if (req_cpu_i && req_dma_i) begin
            if (last_q == GRANT_DMA) gnt_cpu_o = 1'b1;
            else                     gnt_dma_o = 1'b1;
        end else begin
            gnt_cpu_o = req_cpu_i;
            gnt_dma_o = req_dma_i;
        end
        if (gnt_cpu_o)      last_d = GRANT_CPU;
        else if (gnt_dma_o) last_d = GRANT_DMA;
    end

    // Resetting to DMA means the CPU wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_q <= GRANT_DMA;
        else     last_q <= last_d;
    end

endmodule

// File: rtl/vram_port_arbiter.sv
// Shares a 1W/1R VRAM: the write port is round-robin between CPU and DMA. The read port gives video priority over the CPU, with a forced slot for a starved CPU.
// Readiness is combinational. Read data returns exactly 1 cycle after the grant and is steered by a tag. Same-address read/write collisions stall the read.
module vram_port_arbiter
    import vram_arb_pkg::*;
#(
    parameter  int SIZE         = 8,
    parameter  int DEPTH        = 8192,
    parameter  int STARVE_LIMIT = 4,
    localparam int ADDR_W       = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_wr_valid,
    output logic              cpu_wr_ready,
    input  logic [ADDR_W-1:0] cpu_wr_addr,
    input  logic [SIZE-1:0]   cpu_wr_data,
    input  logic              dma_wr_valid,
    output logic              dma_wr_ready,
    input  logic [ADDR_W-1:0] dma_wr_addr,
    input  logic [SIZE-1:0]   dma_wr_data,
    input  logic              vid_rd_valid,
    output logic              vid_rd_ready,
    input  logic [ADDR_W-1:0] vid_rd_addr,
    output logic              vid_rd_data_valid,
    output logic [SIZE-1:0]   vid_rd_data,
    input  logic              cpu_rd_valid,
    output logic              cpu_rd_ready,
    input  logic [ADDR_W-1:0] cpu_rd_addr,
    output logic              cpu_rd_data_valid,
    output logic [SIZE-1:0]   cpu_rd_data,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [SIZE-1:0]   ram_write_data,
    output logic              ram_write_en,
    output logic [ADDR_W-1:0] ram_raddr,
    input  logic [SIZE-1:0]   ram_read_data
);

    logic              wr_gnt_cpu, wr_gnt_dma;
    logic              sel_cpu, sel_vid, rd_hazard;
    logic [ADDR_W-1:0] sel_addr;
    logic              rd_gnt_vid, rd_gnt_cpu;

    rd_tag_e           rd_tag_q, rd_tag_d;
    logic [3:0]        cpu_starve_q, cpu_starve_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;

    rr_arbiter_2 u_wr_arb (
        .clk       (clk),
        .rst       (rst),
        .req_cpu_i (cpu_wr_valid),
        .req_dma_i (dma_wr_valid),
        .gnt_cpu_o (wr_gnt_cpu),
        .gnt_dma_o (wr_gnt_dma)
    );

    always_comb begin
        ram_write_en   = 1'b0;
        ram_waddr      = '0;
        ram_write_data = '0;
        if (!rst && wr_gnt_cpu) begin
            ram_write_en   = 1'b1;
            ram_waddr      = cpu_wr_addr;
            ram_write_data = cpu_wr_data;
        end else if (!rst && wr_gnt_dma) begin
            ram_write_en   = 1'b1;
            ram_waddr      = dma_wr_addr;
            ram_write_data = dma_wr_data;
        end
        // During reset every requester is drained: ready mirrors valid, nothing reaches the RAM.
        cpu_wr_ready = rst ? cpu_wr_valid : wr_gnt_cpu;
        dma_wr_ready = rst ? dma_wr_valid : wr_gnt_dma;
    end

    always_comb begin
        sel_cpu    = cpu_rd_valid &&
                     (!vid_rd_valid || (cpu_starve_q >= 4'(STARVE_LIMIT)));
        sel_vid    = vid_rd_valid && !sel_cpu;
        sel_addr   = sel_cpu ? cpu_rd_addr : vid_rd_addr;
        rd_hazard  = ram_write_en && (sel_addr == ram_waddr);
        rd_gnt_vid = !rst && sel_vid && !rd_hazard;
        rd_gnt_cpu = !rst && sel_cpu && !rd_hazard;

        vid_rd_ready = rst ? vid_rd_valid : rd_gnt_vid;
        cpu_rd_ready = rst ? cpu_rd_valid : rd_gnt_cpu;

        raddr_d  = raddr_q;
        rd_tag_d = TAG_NONE;
        if (rd_gnt_vid) begin
            raddr_d  = vid_rd_addr;
            rd_tag_d = TAG_VID;
        end else if (rd_gnt_cpu) begin
            raddr_d  = cpu_rd_addr;
            rd_tag_d = TAG_CPU;
        end
        ram_raddr = raddr_d;

        // A hazard-blocked CPU read counts as a lost cycle, the same as losing to video.
        cpu_starve_d = cpu_starve_q;
        if (!cpu_rd_valid || rd_gnt_cpu) cpu_starve_d = '0;
        else if (cpu_starve_q != 4'hF)   cpu_starve_d = cpu_starve_q + 4'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_tag_q     <= TAG_NONE;
            cpu_starve_q <= '0;
            raddr_q      <= '0;
        end else begin
            rd_tag_q     <= rd_tag_d;
            cpu_starve_q <= cpu_starve_d;
            raddr_q      <= raddr_d;
        end
    end

    assign vid_rd_data_valid = (rd_tag_q == TAG_VID);
    assign cpu_rd_data_valid = (rd_tag_q == TAG_CPU);
    assign vid_rd_data       = ram_read_data;
    assign cpu_rd_data       = ram_read_data;

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Directed bench for vram_port_arbiter with a behavioural 1-cycle VRAM model.
module tb_vram_port_arbiter;

    localparam int AW = 13;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_wr_valid, cpu_wr_ready, dma_wr_valid, dma_wr_ready;
    logic [AW-1:0] cpu_wr_addr, dma_wr_addr, vid_rd_addr, cpu_rd_addr;
    logic [DW-1:0] cpu_wr_data, dma_wr_data;
    logic          vid_rd_valid, vid_rd_ready, vid_rd_data_valid;
    logic          cpu_rd_valid, cpu_rd_ready, cpu_rd_data_valid;
    logic [DW-1:0] vid_rd_data, cpu_rd_data;
    logic [AW-1:0] ram_waddr, ram_raddr;
    logic [DW-1:0] ram_write_data, ram_read_data;
    logic          ram_write_en;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vram_port_arbiter dut (
        .clk(clk), .rst(rst),
        .cpu_wr_valid(cpu_wr_valid), .cpu_wr_ready(cpu_wr_ready),
        .cpu_wr_addr(cpu_wr_addr), .cpu_wr_data(cpu_wr_data),
        .dma_wr_valid(dma_wr_valid), .dma_wr_ready(dma_wr_ready),
        .dma_wr_addr(dma_wr_addr), .dma_wr_data(dma_wr_data),
        .vid_rd_valid(vid_rd_valid), .vid_rd_ready(vid_rd_ready),
        .vid_rd_addr(vid_rd_addr), .vid_rd_data_valid(vid_rd_data_valid),
        .vid_rd_data(vid_rd_data),
        .cpu_rd_valid(cpu_rd_valid), .cpu_rd_ready(cpu_rd_ready),
        .cpu_rd_addr(cpu_rd_addr), .cpu_rd_data_valid(cpu_rd_data_valid),
        .cpu_rd_data(cpu_rd_data),
        .ram_waddr(ram_waddr), .ram_write_data(ram_write_data),
        .ram_write_en(ram_write_en), .ram_raddr(ram_raddr),
        .ram_read_data(ram_read_data)
    );

    // VRAM model: preloaded on the first edge, then registered read and write.
    logic [DW-1:0] mem [0:8191];
    bit            mem_ready = 1'b0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 8192; i++) mem[i] <= '0;
            mem[13'h100] <= 8'h3C;
            mem[13'h101] <= 8'hC3;
            mem[13'h060] <= 8'h66;
            mem[13'h040] <= 8'h00;
            mem_ready    <= 1'b1;
        end else begin
            if (ram_write_en) mem[ram_waddr] <= ram_write_data;
            ram_read_data <= mem[ram_raddr];
        end
    end

    typedef struct {
        logic          cwv; logic [AW-1:0] cwa; logic [DW-1:0] cwd;
        logic          dwv; logic [AW-1:0] dwa; logic [DW-1:0] dwd;
        logic          vrv; logic [AW-1:0] vra;
        logic          crv; logic [AW-1:0] cra;
        logic          e_cw, e_dw, e_vr, e_cr, e_wen;
        logic [AW-1:0] e_wa; logic [DW-1:0] e_wd;
        logic          e_vdv, e_cdv; logic [DW-1:0] e_rd;
    } vec_t;

    function automatic vec_t mk(
        logic cwv, logic [AW-1:0] cwa, logic [DW-1:0] cwd,
        logic dwv, logic [AW-1:0] dwa, logic [DW-1:0] dwd,
        logic vrv, logic [AW-1:0] vra, logic crv, logic [AW-1:0] cra,
        logic e_cw, logic e_dw, logic e_vr, logic e_cr,
        logic e_wen, logic [AW-1:0] e_wa, logic [DW-1:0] e_wd,
        logic e_vdv, logic e_cdv, logic [DW-1:0] e_rd);
        vec_t v;
        v.cwv = cwv; v.cwa = cwa; v.cwd = cwd;
        v.dwv = dwv; v.dwa = dwa; v.dwd = dwd;
        v.vrv = vrv; v.vra = vra; v.crv = crv; v.cra = cra;
        v.e_cw = e_cw; v.e_dw = e_dw; v.e_vr = e_vr; v.e_cr = e_cr;
        v.e_wen = e_wen; v.e_wa = e_wa; v.e_wd = e_wd;
        v.e_vdv = e_vdv; v.e_cdv = e_cdv; v.e_rd = e_rd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        cpu_wr_valid = v.cwv; cpu_wr_addr = v.cwa; cpu_wr_data = v.cwd;
        dma_wr_valid = v.dwv; dma_wr_addr = v.dwa; dma_wr_data = v.dwd;
        vid_rd_valid = v.vrv; vid_rd_addr = v.vra;
        cpu_rd_valid = v.crv; cpu_rd_addr = v.cra;
    endtask

    vec_t vecs [14];
    vec_t idle;

    initial begin
        idle = mk(0,0,0, 0,0,0, 0,0, 0,0, 0,0,0,0, 0,0,0, 0,0,0);
        vecs[0]  = idle;
        vecs[1]  = mk(1,'h10,'hA1, 1,'h20,'hB2, 0,0, 0,0, 1,0,0,0, 1,'h10,'hA1, 0,0,0);
        vecs[2]  = mk(1,'h10,'hA1, 1,'h20,'hB2, 0,0, 0,0, 0,1,0,0, 1,'h20,'hB2, 0,0,0);
        vecs[3]  = vecs[1];
        vecs[4]  = vecs[2];
        vecs[5]  = mk(0,'h10,'hA1, 1,'h20,'hB2, 0,0, 0,0, 0,1,0,0, 1,'h20,'hB2, 0,0,0);
        vecs[6]  = vecs[1];
        vecs[7]  = mk(0,0,0, 0,0,0, 1,'h100, 0,0, 0,0,1,0, 0,0,0, 0,0,0);
        vecs[8]  = mk(0,0,0, 0,0,0, 0,0, 1,'h101, 0,0,0,1, 0,0,0, 1,0,'h3C);
        vecs[9]  = mk(0,0,0, 0,0,0, 0,0, 0,0, 0,0,0,0, 0,0,0, 0,1,'hC3);
        vecs[10] = mk(0,0,0, 0,0,0, 1,'h100, 1,'h101, 0,0,1,0, 0,0,0, 0,0,0);
        vecs[11] = mk(0,0,0, 0,0,0, 0,0, 0,0, 0,0,0,0, 0,0,0, 1,0,'h3C);
        vecs[12] = mk(1,'h50,'h77, 0,0,0, 1,'h60, 0,0, 1,0,1,0, 1,'h50,'h77, 0,0,0);
        vecs[13] = mk(0,0,0, 0,0,0, 0,0, 0,0, 0,0,0,0, 0,0,0, 1,0,'h66);

        // Reset state: readies follow valids, no writes, no read returns.
        rst = 1'b1;
        drive(idle);
        cpu_rd_valid = 1'b1;
        cpu_wr_valid = 1'b1;
        #2;
        chk("rst_cpu_rd_ready", cpu_rd_ready, 1);
        chk("rst_cpu_wr_ready", cpu_wr_ready, 1);
        chk("rst_wen", ram_write_en, 0);
        chk("rst_vdv", vid_rd_data_valid, 0);
        chk("rst_cdv", cpu_rd_data_valid, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive(idle);

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            chk($sformatf("v%0d_cpu_wr_ready", i), cpu_wr_ready, vecs[i].e_cw);
            chk($sformatf("v%0d_dma_wr_ready", i), dma_wr_ready, vecs[i].e_dw);
            chk($sformatf("v%0d_vid_rd_ready", i), vid_rd_ready, vecs[i].e_vr);
            chk($sformatf("v%0d_cpu_rd_ready", i), cpu_rd_ready, vecs[i].e_cr);
            chk($sformatf("v%0d_wen", i), ram_write_en, vecs[i].e_wen);
            chk($sformatf("v%0d_waddr", i), ram_waddr, vecs[i].e_wa);
            chk($sformatf("v%0d_wdata", i), ram_write_data, vecs[i].e_wd);
            chk($sformatf("v%0d_vdv", i), vid_rd_data_valid, vecs[i].e_vdv);
            chk($sformatf("v%0d_cdv", i), cpu_rd_data_valid, vecs[i].e_cdv);
            if (vecs[i].e_vdv) chk($sformatf("v%0d_vdata", i), vid_rd_data, vecs[i].e_rd);
            if (vecs[i].e_cdv) chk($sformatf("v%0d_cdata", i), cpu_rd_data, vecs[i].e_rd);
        end

        // Starvation: both reads held; CPU forced in on cycles 5 and 10.
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            drive(idle);
            vid_rd_valid = 1'b1; vid_rd_addr = 13'h100;
            cpu_rd_valid = 1'b1; cpu_rd_addr = 13'h101;
            #1;
            chk($sformatf("st%0d_vid_ready", c), vid_rd_ready, (c != 5 && c != 10));
            chk($sformatf("st%0d_cpu_ready", c), cpu_rd_ready, (c == 5 || c == 10));
            chk($sformatf("st%0d_vdv", c), vid_rd_data_valid,
                (c >= 2 && c != 6));
            chk($sformatf("st%0d_cdv", c), cpu_rd_data_valid, (c == 6));
        end
        @(negedge clk);
        drive(idle);
        #1;
        chk("st_end_cdv", cpu_rd_data_valid, 1);
        chk("st_end_cdata", cpu_rd_data, 8'hC3);

        // Same-address hazard: CPU writes 0x55 to 0x40 while video reads 0x40.
        @(negedge clk);
        drive(idle);
        cpu_wr_valid = 1'b1; cpu_wr_addr = 13'h40; cpu_wr_data = 8'h55;
        vid_rd_valid = 1'b1; vid_rd_addr = 13'h40;
        #1;
        chk("hz_vid_ready", vid_rd_ready, 0);
        chk("hz_cpu_wr_ready", cpu_wr_ready, 1);
        chk("hz_wen", ram_write_en, 1);
        @(negedge clk);
        cpu_wr_valid = 1'b0;
        #1;
        chk("hz_retry_ready", vid_rd_ready, 1);
        chk("hz_retry_raddr", ram_raddr, 13'h40);
        @(negedge clk);
        drive(idle);
        #1;
        chk("hz_vdv", vid_rd_data_valid, 1);
        chk("hz_vdata", vid_rd_data, 8'h55);

        // Reset one cycle after a video grant: the in-flight read is dropped.
        @(negedge clk);
        vid_rd_valid = 1'b1; vid_rd_addr = 13'h100;
        #1;
        chk("rs_vid_ready", vid_rd_ready, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        vid_rd_valid = 1'b0;
        cpu_wr_valid = 1'b1; cpu_wr_addr = 13'h10;
        #1;
        chk("rs_vdv_dropped", vid_rd_data_valid, 0);
        chk("rs_wen", ram_write_en, 0);
        chk("rs_cpu_wr_ready", cpu_wr_ready, 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cpu_wr_valid = 1'b1; cpu_wr_addr = 13'h10; cpu_wr_data = 8'hA1;
        dma_wr_valid = 1'b1; dma_wr_addr = 13'h20; dma_wr_data = 8'hB2;
        #1;
        chk("rs_tie_cpu", cpu_wr_ready, 1);
        chk("rs_tie_dma", dma_wr_ready, 0);
        chk("rs_vdv_after", vid_rd_data_valid, 0);
        @(negedge clk);
        drive(idle);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vram_port_arbiter.md
Name: vram_port_arbiter

Overview:
- Shares one simple dual-port VRAM (1 write port, 1 read port, 1-cycle registered read latency) between PPU requesters.
- Write port: CPU writes and DMA tile loader, round-robin.
- Read port: video scanline fetch (priority) and CPU readback, with an anti-starvation slot for the CPU.
- Prevents same-address read/write in one cycle, which the RAM leaves undefined.
- Tags each read so returning data is steered to the requester that issued it.

Parameters:
- SIZE, 8, word width in bits.
- DEPTH, 8192, RAM entries; ADDR_W = $clog2(DEPTH).
- STARVE_LIMIT, 4, consecutive lost CPU-read cycles before the CPU is forced a read grant (1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cpu_wr_valid/cpu_wr_ready  in/out  1/1  CPU write handshake.
- cpu_wr_addr/cpu_wr_data  in  ADDR_W/SIZE  CPU write address/data.
- dma_wr_valid/dma_wr_ready  in/out  1/1  DMA write handshake.
- dma_wr_addr/dma_wr_data  in  ADDR_W/SIZE  DMA write address/data.
- vid_rd_valid/vid_rd_ready  in/out  1/1  video read handshake.
- vid_rd_addr  in  ADDR_W  video read address.
- vid_rd_data_valid  out  1  video read data valid.
- vid_rd_data  out  SIZE  video read data.
- cpu_rd_valid/cpu_rd_ready  in/out  1/1  CPU read handshake.
- cpu_rd_addr  in  ADDR_W  CPU read address.
- cpu_rd_data_valid  out  1  CPU read data valid.
- cpu_rd_data  out  SIZE  CPU read data.
- ram_waddr/ram_write_data/ram_write_en  out  ADDR_W/SIZE/1  to RAM write port.
- ram_raddr  out  ADDR_W  to RAM read port.
- ram_read_data  in  SIZE  from RAM, valid one cycle after ram_raddr is sampled.

Behaviour:
- Handshake: a transfer happens on a clk edge with valid&ready. ready is combinational from the valids and the arbiter state. Requesters hold addr/data stable while valid is high and not ready.
- Write arbitration: exactly one write is granted per cycle.
  - Only one valid: that requester is granted.
  - Both valid: the requester not granted last time wins.
  - last_wr_grant register updates only on a granted write. Reset value = DMA, so the CPU wins the first tie.
  - ram_write_en = granted valid. ram_waddr and ram_write_data are muxed from the winner; they are 0 when idle.
- Read arbitration: the video requester has priority, with one exception.
  - Forced CPU slot: when cpu_starve reaches STARVE_LIMIT and cpu_rd_valid=1, the CPU is granted over video.
  - cpu_starve (4 bits) increments, saturating, each cycle the CPU read is valid but not granted.
  - cpu_starve clears on a CPU read grant, or when cpu_rd_valid=0.
- Hazard: if the selected read address equals ram_waddr while ram_write_en=1, no read is granted that cycle (both rd_ready=0). The write proceeds, and the read retries next cycle and sees the new data.
  - A hazard-blocked CPU read still counts toward cpu_starve.
- Read tag: rd_tag register (2 bits: none/vid/cpu) captures the granted read's owner each cycle.
  - Next cycle: vid_rd_data_valid = (tag==vid), cpu_rd_data_valid = (tag==cpu).
  - Both *_rd_data = ram_read_data, meaningful only while the matching valid is high.
  - Read latency is exactly 1 cycle. One read can be granted every cycle (full throughput).
- ram_raddr = granted read address; it holds its previous value when no read is granted.
- Reset (async assert, applies immediately):
  - rd_tag=none, both rd_data_valid=0, cpu_starve=0, last_wr_grant=DMA.
  - All ready outputs follow their valids combinationally; ram_write_en=0 while rst=1.
  - A read in flight when reset asserts is dropped: no data_valid is produced.
- Simultaneous events: one write, one read and one data return can all occur in the same cycle, provided the read and write addresses differ.

Decomposition:
- Package vram_arb_pkg: tag encodings (TAG_NONE=0, TAG_VID=1, TAG_CPU=2) and the grant encoding (GRANT_CPU, GRANT_DMA).
- Sub-module rr_arbiter_2: 2-way round-robin with a last-grant register. It is used for the write port. Read selection is inline priority logic plus the starvation counter.

Test Plan:
- Both writes valid for 4 cycles (CPU addr 0x10 data 0xA1, DMA addr 0x20 data 0xB2) -> grants alternate CPU,DMA,CPU,DMA; ram_write_en=1 all 4 cycles.
- Video read addr 0x100, then CPU read addr 0x101, on an idle bus -> vid_rd_data_valid on cycle+1 carrying mem[0x100]; cpu_rd_data_valid on the following cycle carrying mem[0x101]; never both in one cycle.
- vid_rd_valid and cpu_rd_valid held high, STARVE_LIMIT=4 -> CPU granted on cycle 5, video on cycles 1-4 and 6-9, CPU again on cycle 10.
- CPU writes 0x55 to 0x40 while video reads 0x40 in the same cycle -> vid_rd_ready=0 that cycle; read granted next cycle; returns 0x55.
- Reset asserted mid-stream, one cycle after a video read grant -> vid_rd_data_valid stays 0; after release, the first tied write goes to the CPU.
